mem_bus_master: RTL and testbench

CPU-side initiator for the 256-byte block RAM. It accepts byte or 16-bit word read/write requests from the core over a req/ack handshake. For each request it drives the RAM's enable, step strobe, write-enable, address and write-data lines, then captures the returned byte(s). A word access is split into two sequential byte accesses, low byte first.

---
 rtl/mem_if_pkg.sv | 23 ++
 rtl/mem_strobe_gen.sv | 34 +++
 rtl/mem_bus_master.sv | 157 +++++++++++++++
 tb/tb_mem_bus_master.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_if_pkg.sv
// Shared types and constants for the block-RAM bus master.
// Word accesses are compiled in only when MEM_WORD_EN is defined (see mem_bus_master).
package mem_if_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    STROBE_H,
    STROBE_L,
    DONE
  } state_e;

  typedef struct packed {
    logic                  write;
    logic                  word;
    logic [ADDR_W-1:0]     addr;
    logic [2*DATA_W-1:0]   wdata;
  } mem_op_t;

endpackage

// File: rtl/mem_strobe_gen.sv
// Phase counter for the RAM step strobe: a down-counter loaded with the high or
// low phase length, reporting phase_done_o on its terminal count.
module mem_strobe_gen #(
  parameter int STROBE_HIGH = 4,
  parameter int STROBE_LOW  = 4
) (
  input  logic clk_qzt,
  input  logic rst_n,
  input  logic load_high_i,
  input  logic load_low_i,
  output logic phase_done_o
);

  localparam int MAX_PH = (STROBE_HIGH > STROBE_LOW) ? STROBE_HIGH : STROBE_LOW;
  localparam int CNT_W  = (MAX_PH > 1) ? $clog2(MAX_PH) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_qzt or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // Loaded with N-1 so the phase lasts exactly N cycles including the terminal one.
  always_comb begin
    cnt_d = cnt_q;
    if (load_high_i)       cnt_d = CNT_W'(STROBE_HIGH - 1);
    else if (load_low_i)   cnt_d = CNT_W'(STROBE_LOW - 1);
    else if (cnt_q != '0)  cnt_d = cnt_q - 1'b1;
  end

  assign phase_done_o = (cnt_q == '0);

endmodule

// File: rtl/mem_bus_master.sv
// CPU-side initiator for the 256-byte block RAM: byte/word accesses over req/ack.
// Define MEM_WORD_EN to enable 16-bit word accesses; otherwise every access is a byte.
module mem_bus_master
  import mem_if_pkg::*;
#(
  parameter int STROBE_HIGH = 4,
  parameter int STROBE_LOW  = 4
) (
  input  logic                  clk_qzt,
  input  logic                  rst_n,
  input  logic                  req,
  input  logic                  op_write,
  input  logic                  op_word,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic                  ack,
  output logic                  busy,
  output logic [2*DATA_W-1:0]   rdata,
  output logic                  mem_en,
  output logic                  mem_clk,
  output logic                  mem_write_en,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_data_in,
  input  logic [DATA_W-1:0]     mem_data_out
);

  state_e               state_q, state_d;
  mem_op_t              op_q, op_d;
  logic                 byte_idx_q, byte_idx_d;
  logic [DATA_W-1:0]    byte0_q, byte0_d;
  logic [2*DATA_W-1:0]  rdata_q, rdata_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    din_q, din_d;
  logic                 ack_q, ack_d;
  logic                 busy_q, busy_d;
  logic                 en_q, en_d;
  logic                 mclk_q, mclk_d;
  logic                 we_q, we_d;
  logic                 load_high, load_low, phase_done;
  logic                 word_ok;

`ifdef MEM_WORD_EN
  assign word_ok = op_word;
`else
  assign word_ok = op_word & 1'b0;
`endif

  mem_strobe_gen #(
    .STROBE_HIGH (STROBE_HIGH),
    .STROBE_LOW  (STROBE_LOW)
  ) u_strobe (
    .clk_qzt      (clk_qzt),
    .rst_n        (rst_n),
    .load_high_i  (load_high),
    .load_low_i   (load_low),
    .phase_done_o (phase_done)
  );

  always_ff @(posedge clk_qzt or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      op_q       <= '0;
      byte_idx_q <= 1'b0;
      byte0_q    <= '0;
      rdata_q    <= '0;
      addr_q     <= '0;
      din_q      <= '0;
      ack_q      <= 1'b0;
      busy_q     <= 1'b0;
      en_q       <= 1'b0;
      mclk_q     <= 1'b0;
      we_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      byte_idx_q <= byte_idx_d;
      byte0_q    <= byte0_d;
      rdata_q    <= rdata_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      ack_q      <= ack_d;
      busy_q     <= busy_d;
      en_q       <= en_d;
      mclk_q     <= mclk_d;
      we_q       <= we_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    byte_idx_d = byte_idx_q;
    byte0_d    = byte0_q;
    rdata_d    = rdata_q;
    load_high  = 1'b0;
    load_low   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          op_d       = '{write: op_write, word: word_ok, addr: req_addr, wdata: req_wdata};
          byte_idx_d = 1'b0;
          state_d    = SETUP;
        end
      end
      SETUP: begin
        load_high = 1'b1;
        state_d   = STROBE_H;
      end
      STROBE_H: begin
        if (phase_done) begin
          load_low = 1'b1;
          state_d  = STROBE_L;
        end
      end
      STROBE_L: begin
        if (phase_done) begin
          if (op_q.word && !byte_idx_q) begin
            byte0_d    = mem_data_out;
            byte_idx_d = 1'b1;
            state_d    = SETUP;
          end else begin
            // rdata only changes on the edge into DONE so it stays stable between acks.
            rdata_d = op_q.word ? {mem_data_out, byte0_q} : {{DATA_W{1'b0}}, mem_data_out};
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so the strobe is glitch-free.
  always_comb begin
    ack_d  = (state_d == DONE);
    busy_d = (state_d != IDLE);
    en_d   = (state_d == SETUP) || (state_d == STROBE_H) || (state_d == STROBE_L);
    mclk_d = (state_d == STROBE_H);
    we_d   = en_d && op_d.write;
    addr_d = addr_q;
    din_d  = din_q;
    if (state_d == SETUP) begin
      addr_d = op_d.addr + ADDR_W'(byte_idx_d);
      din_d  = byte_idx_d ? op_d.wdata[2*DATA_W-1:DATA_W] : op_d.wdata[DATA_W-1:0];
    end
  end

  assign ack          = ack_q;
  assign busy         = busy_q;
  assign rdata        = rdata_q;
  assign mem_en       = en_q;
  assign mem_clk      = mclk_q;
  assign mem_write_en = we_q;
  assign mem_addr     = addr_q;
  assign mem_data_in  = din_q;

endmodule

// File: tb/tb_mem_bus_master.sv
// Self-checking bench for mem_bus_master with a behavioural read-first RAM that
// samples the step strobe on clk_qzt; MEM_WORD_EN selects the word-capable model.
module tb_mem_bus_master;

  localparam int H = 4;
  localparam int L = 4;
`ifdef MEM_WORD_EN
  localparam bit WORD_EN = 1'b1;
`else
  localparam bit WORD_EN = 1'b0;
`endif

  logic        clk_qzt = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        op_write = 1'b0;
  logic        op_word = 1'b0;
  logic [7:0]  req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        ack, busy, mem_en, mem_clk, mem_write_en;
  logic [15:0] rdata;
  logic [7:0]  mem_addr, mem_data_in;
  logic [7:0]  mem_data_out = '0;

  int errors = 0;
  int checks = 0;

  always #5 clk_qzt = ~clk_qzt;

  mem_bus_master #(.STROBE_HIGH(H), .STROBE_LOW(L)) dut (
    .clk_qzt      (clk_qzt),
    .rst_n        (rst_n),
    .req          (req),
    .op_write     (op_write),
    .op_word      (op_word),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .ack          (ack),
    .busy         (busy),
    .rdata        (rdata),
    .mem_en       (mem_en),
    .mem_clk      (mem_clk),
    .mem_write_en (mem_write_en),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  // RAM: acts once after seeing the strobe high on two consecutive clk_qzt samples.
  logic [7:0] ram [256];
  int         ram_hi = 0;
  logic       pl_go = 1'b0;
  logic [7:0] pl_a = '0, pl_d = '0;

  always @(posedge clk_qzt) begin
    if (pl_go) ram[pl_a] <= pl_d;
    if (mem_en && mem_clk) begin
      ram_hi <= ram_hi + 1;
      if (ram_hi == 1) begin
        mem_data_out <= ram[mem_addr];
        if (mem_write_en) ram[mem_addr] <= mem_data_in;
      end
    end else begin
      ram_hi <= 0;
    end
  end

  int mdl [256];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int a, input int d);
    @(negedge clk_qzt);
    pl_a  = a[7:0];
    pl_d  = d[7:0];
    pl_go = 1'b1;
    @(negedge clk_qzt);
    pl_go = 1'b0;
    mdl[a] = d;
  endtask

  task automatic do_access(input bit w, input bit wd, input int a, input int d);
    bit we_seen;
    int weff, a1, exp_rd, lat, cyc, ack_cyc, hi_cnt;
    weff   = (wd && WORD_EN) ? 1 : 0;
    a1     = (a + 1) % 256;
    exp_rd = weff ? (mdl[a] + 256 * mdl[a1]) : mdl[a];
    lat    = weff ? 2 * (H + L) + 3 : H + L + 2;
    if (w) begin
      mdl[a] = d % 256;
      if (weff) mdl[a1] = (d / 256) % 256;
    end
    @(negedge clk_qzt);
    req = 1'b1; op_write = w; op_word = wd; req_addr = a[7:0]; req_wdata = d[15:0];
    @(posedge clk_qzt); #1;
    req = 1'b0;
    cyc = 1; ack_cyc = 0; hi_cnt = 0; we_seen = 1'b0;
    while (cyc <= 60) begin
      if (cyc == 1) begin
        chk("busy_rise", busy, 1);
        chk("addr_b0", mem_addr, a);
        if (w) chk("din_b0", mem_data_in, d % 256);
      end
      if (weff && cyc == H + L + 2) begin
        chk("addr_b1", mem_addr, a1);
        if (w) chk("din_b1", mem_data_in, (d / 256) % 256);
      end
      if (mem_write_en) we_seen = 1'b1;
      if (mem_clk) hi_cnt++;
      if (ack) begin
        ack_cyc = cyc;
        break;
      end
      @(posedge clk_qzt); #1;
      cyc++;
    end
    chk("ack_cycle", ack_cyc, lat);
    chk("rdata", rdata, exp_rd);
    chk("write_en_seen", we_seen, w);
    chk("strobe_high_cycles", hi_cnt, H * (weff + 1));
    @(posedge clk_qzt); #1;
    chk("ack_busy_after", {ack, busy}, 0);
    chk("ram_b0", ram[a], mdl[a]);
    if (weff) chk("ram_b1", ram[a1], mdl[a1]);
  endtask

  initial begin
    int acks [$];
    int target, cyc;

    repeat (3) @(posedge clk_qzt);
    #1;
    chk("reset_outputs", {ack, busy, rdata, mem_en, mem_clk, mem_write_en, mem_addr, mem_data_in}, 0);
    for (int i = 0; i < 256; i++) preload(i, int'($urandom_range(255)));
    @(negedge clk_qzt);
    rst_n = 1'b1;
    repeat (2) @(posedge clk_qzt);

    preload(8'h10, 8'hA5);
    do_access(1'b0, 1'b0, 8'h10, 0);
    chk("byte_read_a5", rdata, 16'h00A5);

    do_access(1'b1, 1'b0, 8'h20, 16'h003C);
    do_access(1'b0, 1'b0, 8'h20, 0);
    chk("byte_readback_3c", rdata, 16'h003C);

    do_access(1'b1, 1'b1, 8'h40, 16'hBEEF);
    do_access(1'b0, 1'b1, 8'h40, 0);
    chk("word_readback", rdata, WORD_EN ? 16'hBEEF : 16'h00EF);

    preload(8'hFF, 8'h11);
    preload(8'h00, 8'h22);
    do_access(1'b0, 1'b1, 8'hFF, 0);
    chk("word_wrap", rdata, WORD_EN ? 16'h2211 : 16'h0011);

    // req held high for 40 sampled cycles: back-to-back byte reads, no queuing.
    @(negedge clk_qzt);
    req = 1'b1; op_write = 1'b0; op_word = 1'b0; req_addr = 8'h10; req_wdata = '0;
    for (int k = 1; k <= 70; k++) begin
      @(posedge clk_qzt); #1;
      if (ack) acks.push_back(k);
      if (k == 40) req = 1'b0;
    end
    chk("hold_ack_count", acks.size(), 4);
    if (acks.size() > 0) chk("hold_first_ack", acks[0], H + L + 2);
    for (int i = 1; i < acks.size(); i++) chk("hold_ack_spacing", acks[i] - acks[i-1], 11);
    chk("hold_rdata", rdata, mdl[8'h10]);

    // Reset in the second STROBE_H cycle of the last byte of a word write.
    preload(8'h80, 8'h5A);
    preload(8'h81, 8'hC3);
    @(negedge clk_qzt);
    req = 1'b1; op_write = 1'b1; op_word = 1'b1; req_addr = 8'h80; req_wdata = 16'h1234;
    @(posedge clk_qzt); #1;
    req = 1'b0;
    target = (WORD_EN ? H + L + 2 : 0) + 2;
    cyc = 1;
    while (cyc < target) begin
      @(posedge clk_qzt); #1;
      cyc++;
    end
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs", {ack, busy, rdata, mem_en, mem_clk, mem_write_en, mem_addr, mem_data_in}, 0);
    if (WORD_EN) mdl[8'h80] = 8'h34;
    @(negedge clk_qzt);
    rst_n = 1'b1;
    repeat (2) @(posedge clk_qzt);
    chk("midreset_ram_b0", ram[8'h80], mdl[8'h80]);
    chk("midreset_ram_b1", ram[8'h81], mdl[8'h81]);
    do_access(1'b0, 1'b1, 8'h80, 0);

    for (int i = 0; i < 40; i++)
      do_access(bit'($urandom_range(1)), bit'($urandom_range(1)),
                int'($urandom_range(255)), int'($urandom_range(65535)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
